// File: rtl/vout_tlc5615.sv
// TLC5615 serial DAC writer: sends {code,2'b00} MSB first whenever dac_value
// differs from the last code sent, and once unconditionally after reset.
module vout_tlc5615 #(
    parameter int unsigned SPEED     = 24,
    parameter int unsigned GAP_TICKS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] dac_value,
    output logic       dac_sclk,
    output logic       dac_din,
    output logic       dac_cs_n,
    output logic       busy
);

    localparam int unsigned DIV_BITS = $clog2(SPEED + 1);
    localparam int unsigned DIV_W    = (DIV_BITS < 8) ? 8 : DIV_BITS;
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(SPEED);
    localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);
    localparam logic [7:0]       GAP_LOAD   = 8'(GAP_TICKS);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CSUP,
        GAP
    } state_e;

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;

    state_e     state_q;
    logic [11:0] shreg_q;
    logic [9:0]  last_sent_q;
    logic        force_q;
    logic [3:0]  bitcnt_q;
    logic [7:0]  gap_q;
    logic        sclk_q;
    logic        din_q;
    logic        cs_n_q;
    logic        busy_q;
    logic        pending;

    assign tick = (div_q == '0);

    // NOTE: default assignment first so every path drives div_d and no latch is inferred.
    always_comb begin
        div_d = div_q - DIV_ONE;
        if (tick) begin
            div_d = DIV_RELOAD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= DIV_RELOAD;
        end else begin
            div_q <= div_d;
        end
    end

    // Evaluated only on the IDLE tick, so a change that reverts beforehand is ignored.
    assign pending = force_q || (dac_value != last_sent_q);

    // NOTE: non-blocking assignments throughout so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            last_sent_q <= '0;
            force_q     <= 1'b1;
            bitcnt_q    <= '0;
            gap_q       <= '0;
            sclk_q      <= 1'b0;
            din_q       <= 1'b0;
            cs_n_q      <= 1'b1;
            busy_q      <= 1'b0;
        end else if (tick) begin
            case (state_q)
                IDLE: begin
                    if (pending) begin
                        shreg_q     <= {dac_value, 2'b00};
                        last_sent_q <= dac_value;
                        force_q     <= 1'b0;
                        cs_n_q      <= 1'b0;
                        din_q       <= dac_value[9];
                        busy_q      <= 1'b1;
                        bitcnt_q    <= '0;
                        sclk_q      <= 1'b0;
                        state_q     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!sclk_q) begin
                        sclk_q <= 1'b1;
                    end else begin
                        // Falling edge: present the next bit; zeros shift in behind the frame.
                        sclk_q   <= 1'b0;
                        shreg_q  <= {shreg_q[10:0], 1'b0};
                        din_q    <= shreg_q[10];
                        bitcnt_q <= bitcnt_q + 4'd1;
                        if (bitcnt_q == 4'd11) begin
                            state_q <= CSUP;
                        end
                    end
                end
                CSUP: begin
                    cs_n_q  <= 1'b1;
                    din_q   <= 1'b0;
                    gap_q   <= GAP_LOAD;
                    state_q <= GAP;
                end
                GAP: begin
                    gap_q <= gap_q - 8'd1;
                    if (gap_q <= 8'd1) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dac_sclk = sclk_q;
    assign dac_din  = din_q;
    assign dac_cs_n = cs_n_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_vout_tlc5615.sv
// Directed bench for vout_tlc5615: a pin-level monitor decodes frames and timing,
// and the stimulus sequence compares them against hand-computed values.
module tb_vout_tlc5615;

    localparam int SPD  = 2;
    localparam int TICK = SPD + 1;

    logic       clk = 1'b0;
    logic       rst_n, rst_f_n;
    logic [9:0] val, val_f;
    logic       sclk, din, cs, busy;
    logic       sclk_f, din_f, cs_f, busy_f;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vout_tlc5615 #(.SPEED(SPD), .GAP_TICKS(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .dac_value(val),
        .dac_sclk(sclk), .dac_din(din), .dac_cs_n(cs), .busy(busy)
    );

    vout_tlc5615 #(.SPEED(0), .GAP_TICKS(1)) u_fast (
        .clk(clk), .rst_n(rst_f_n), .dac_value(val_f),
        .dac_sclk(sclk_f), .dac_din(din_f), .dac_cs_n(cs_f), .busy(busy_f)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Per-frame records from the main instance.
    int q_bits[$], q_edges[$], q_sclk_fall[$], q_sclk_rise[$], q_low[$], q_busy0[$], q_post[$];
    int viol = 0;

    initial begin
        logic pc, ps, pd, sf, bz;
        bit   inf, trk;
        int   bits, ne, lo, post;
        pc = 1'b1; ps = 1'b0; pd = 1'b0; sf = 1'b0; bz = 1'b0;
        inf = 0; trk = 0; bits = 0; ne = 0; lo = 0; post = 0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                inf = 0;
                trk = 0;
            end else begin
                if (trk) begin
                    if (busy) post++;
                    else begin
                        q_post.push_back(post);
                        trk = 0;
                    end
                end
                if (pc && !cs) begin
                    inf = 1; bits = 0; ne = 0; lo = 1; sf = sclk; bz = busy;
                end else if (inf && !cs) begin
                    lo++;
                    if (!ps && sclk) begin
                        bits = (bits << 1) | int'(din);
                        ne++;
                    end
                    // Data may only move on a falling SCLK edge while CS is low.
                    if (din !== pd && !(ps && !sclk)) viol++;
                end else if (inf && !pc && cs) begin
                    q_bits.push_back(bits);
                    q_edges.push_back(ne);
                    q_sclk_fall.push_back(int'(sf));
                    q_sclk_rise.push_back(int'(sclk));
                    q_low.push_back(lo);
                    q_busy0.push_back(int'(bz));
                    inf = 0; trk = 1; post = 1;
                end
            end
            pc = cs; ps = sclk; pd = din;
        end
    end

    // CS low/high durations of the SPEED=0 instance, in clk samples.
    int f_low[$], f_gap[$];

    initial begin
        logic pc;
        bit   inf, hv;
        int   lo, hi;
        pc = 1'b1; inf = 0; hv = 0; lo = 0; hi = 0;
        forever begin
            @(negedge clk);
            if (rst_f_n !== 1'b1) begin
                inf = 0;
                hv  = 0;
            end else if (pc && !cs_f) begin
                if (hv) f_gap.push_back(hi);
                hv = 0; inf = 1; lo = 1;
            end else if (inf && !cs_f) begin
                lo++;
            end else if (inf && !pc && cs_f) begin
                f_low.push_back(lo);
                inf = 0; hv = 1; hi = 1;
            end else if (hv && cs_f) begin
                hi++;
            end
            pc = cs_f;
        end
    end

    task automatic wait_frames(input int n, input int budget);
        int k = 0;
        while (q_bits.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (q_bits.size() < n) check("frame_timeout", q_bits.size(), n);
    endtask

    task automatic wait_cs_fall(input int budget);
        int k = 0;
        while (cs !== 1'b0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (cs !== 1'b0) check("cs_fall_timeout", 32'(cs), 0);
    endtask

    task automatic check_frame(input int idx, input logic [9:0] code, input string tag);
        logic [11:0] exp_bits;
        exp_bits = {code, 2'b00};
        check({tag, "_bits"}, q_bits[idx], 32'(exp_bits));
        check({tag, "_edges"}, q_edges[idx], 12);
        check({tag, "_sclk_at_cs_fall"}, q_sclk_fall[idx], 0);
        check({tag, "_sclk_at_cs_rise"}, q_sclk_rise[idx], 0);
        check({tag, "_cs_low_clks"}, q_low[idx], 25 * TICK);
        check({tag, "_busy_in_frame"}, q_busy0[idx], 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cs_n"}, 32'(cs), 1);
        check({tag, "_sclk"}, 32'(sclk), 0);
        check({tag, "_din"}, 32'(din), 0);
        check({tag, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        rst_n = 1'b0; rst_f_n = 1'b0;
        val = 10'h000; val_f = 10'h000;

        // Reset state and the forced frame of 0x000.
        repeat (4) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        wait_frames(1, 400);
        check_frame(0, 10'h000, "force0");
        repeat (60 * TICK) @(negedge clk);
        check("force0_busy_after_gap_clks", q_post[0], 2 * TICK);
        check("force0_no_repeat", q_bits.size(), 1);
        check("force0_busy_idle", 32'(busy), 0);

        // Alternating pattern.
        val = 10'h2AA;
        wait_frames(2, 400);
        check_frame(1, 10'h2AA, "f2aa");
        repeat (60 * TICK) @(negedge clk);
        check("f2aa_single", q_bits.size(), 2);

        // All ones, then a long quiet interval.
        val = 10'h3FF;
        wait_frames(3, 400);
        check_frame(2, 10'h3FF, "f3ff");
        repeat (200 * TICK) @(negedge clk);
        check("f3ff_quiet_frames", q_bits.size(), 3);
        check("f3ff_quiet_busy", 32'(busy), 0);
        check("f3ff_quiet_cs", 32'(cs), 1);

        // Changes during a frame: in-flight frame keeps 0x100, only the newest follows.
        val = 10'h100;
        wait_cs_fall(400);
        repeat (5 * TICK) @(negedge clk);
        val = 10'h155;
        repeat (15 * TICK) @(negedge clk);
        val = 10'h0FF;
        wait_frames(5, 600);
        check_frame(3, 10'h100, "f100");
        check_frame(4, 10'h0FF, "f0ff");
        repeat (80 * TICK) @(negedge clk);
        check("skip_count", q_bits.size(), 5);

        // Reset mid-frame, then the full 0x3C3 frame is resent.
        val = 10'h3C3;
        wait_cs_fall(400);
        repeat (10 * TICK) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_frames(6, 600);
        check_frame(5, 10'h3C3, "f3c3");
        repeat (60 * TICK) @(negedge clk);
        check("f3c3_count", q_bits.size(), 6);
        check("din_stability_violations", viol, 0);

        // SPEED=0, GAP_TICKS=1: forced frame then back-to-back 0x155 frame.
        rst_f_n = 1'b1;
        repeat (10) @(negedge clk);
        val_f = 10'h155;
        begin
            int k = 0;
            while (f_low.size() < 2 && k < 300) begin
                @(negedge clk);
                k++;
            end
        end
        // Edges from the CS-fall tick through the CS-rise tick, inclusive.
        check("fast_cs_fall_to_rise_clks", f_low[0] + 1, 26);
        check("fast_cs_high_between_frames", f_gap[0], 2);
        check("fast_second_frame_clks", f_low[1] + 1, 26);
        repeat (40) @(negedge clk);
        check("fast_busy_idle", 32'(busy_f), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
